// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : boot_pkg
//  Purpose  : Shared types and constants for the UART boot loader
//  Revision : 1.0
// ============================================================================
package boot_pkg;

  // Loader phases: length header, payload words, pipeline running, failed load
  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_DATA = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } boot_state_e;

  // 12 MHz system clock at 9600 baud
  localparam int DEFAULT_CLK_DIV    = 12_000_000 / 9600;
  localparam int IMG_BYTES_PER_WORD = 4;

  // Little-endian assembly: each new byte lands at the top and older bytes
  // slide down, so after four bytes the first one sits in bits [7:0].
  function automatic logic [31:0] insert_byte(input logic [31:0] acc,
                                              input logic [7:0]  b);
    return {b, acc[31:8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Purpose  : 8N1 UART byte receiver with glitch rejection and stop check
//  Revision : 1.0
// ============================================================================
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic [7:0] o_data
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] c_HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] c_FULL_M1 = CW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_sync;
  logic          r_prev;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_valid;
  logic          r_ferr;

  logic w_rx;
  logic w_fall;
  logic w_tick;

  assign w_rx   = r_sync[1];
  assign w_fall = r_prev & ~w_rx;
  assign w_tick = (r_cnt == '0);

  // Synchronise the line, then walk start/data/stop sampling at bit centres
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_prev  <= w_rx;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= c_HALF_M1;
          end
        end
        S_START: begin
          if (w_tick) begin
            // Line back high at mid start bit: a glitch, not a frame
            if (w_rx) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_cnt   <= c_FULL_M1;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= c_FULL_M1;
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          if (w_tick) begin
            r_valid <= w_rx;
            r_ferr  <= ~w_rx;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_ferr;
  assign o_data       = r_shift;

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader
//  Purpose  : Loads a UART program image into memory, then releases the CPU
//  Revision : 1.0
// ============================================================================
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int ADDR_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              cpu_rstn,
  input  logic              cpu_wren,
  input  logic [3:0]        cpu_wmask,
  input  logic [31:0]       cpu_wdata,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              mem_wren,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              error
);

  localparam logic [1:0] S_LEN  = ST_LEN;
  localparam logic [1:0] S_DATA = ST_DATA;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_ERR  = ST_ERR;

  // Largest legal word count; compared with one extra bit so 2^ADDR_W fits
  localparam logic [32:0]   c_CAP      = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] c_WCNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic              w_byte_valid;
  logic              w_frame_err;
  logic [7:0]        w_byte;
  logic [31:0]       w_word;
  logic              w_last_byte;
  logic              w_len_too_big;
  logic [ADDR_W:0]   w_wcnt_next;
  logic              w_done;

  logic [1:0]        r_state;
  logic [1:0]        r_bcnt;
  logic [31:0]       r_acc;
  logic [31:0]       r_len;
  logic [ADDR_W:0]   r_wcnt;
  logic              r_wren;
  logic [3:0]        r_wmask;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rstn;

  uart_rx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (uart_rx),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_frame_err),
    .o_data       (w_byte)
  );

  assign w_word        = insert_byte(r_acc, w_byte);
  assign w_last_byte   = (r_bcnt == 2'(IMG_BYTES_PER_WORD - 1));
  assign w_len_too_big = ({1'b0, w_word} > c_CAP);
  assign w_wcnt_next   = r_wcnt + c_WCNT_ONE;
  assign w_done        = (32'(w_wcnt_next) == r_len);

  // Loader sequencing: header, payload words with registered writes, terminal states
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LEN;
      r_bcnt  <= '0;
      r_acc   <= '0;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_wren  <= 1'b0;
      r_wmask <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_rstn  <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        S_LEN: begin
          if (w_frame_err) begin
            r_state <= S_ERR;
          end else if (w_byte_valid) begin
            r_acc  <= w_word;
            r_bcnt <= r_bcnt + 2'd1;
            if (w_last_byte) begin
              r_len  <= w_word;
              r_wcnt <= '0;
              if (w_word == 32'd0) begin
                // Empty image: release the pipeline straight away
                r_state <= S_RUN;
                r_rstn  <= 1'b1;
              end else if (w_len_too_big) begin
                r_state <= S_ERR;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (w_frame_err) begin
            r_state <= S_ERR;
          end else if (w_byte_valid) begin
            r_acc  <= w_word;
            r_bcnt <= r_bcnt + 2'd1;
            if (w_last_byte) begin
              r_wren  <= 1'b1;
              r_wmask <= 4'hF;
              r_wdata <= w_word;
              r_addr  <= r_wcnt[ADDR_W-1:0];
              r_wcnt  <= w_wcnt_next;
              if (w_done) r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Held one cycle behind RUN entry so the final write still reaches memory
          r_rstn <= 1'b1;
        end
        default: begin
          r_rstn <= 1'b0;
        end
      endcase
    end
  end

  // Memory port ownership follows the pipeline reset release
  always_comb begin
    mem_wren  = r_wren;
    mem_wmask = r_wmask;
    mem_wdata = r_wdata;
    mem_addr  = r_addr;
    if (r_rstn) begin
      mem_wren  = cpu_wren;
      mem_wmask = cpu_wmask;
      mem_wdata = cpu_wdata;
      mem_addr  = cpu_addr;
    end
  end

  assign cpu_rstn = r_rstn;
  assign busy     = (r_state != S_RUN);
  assign error    = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
# uart_boot_loader

Boot-time controller for the on-chip instruction/data memory: holds the pipeline in reset, receives a program image over the UART receive line (8N1), writes it word by word into the memory through the single memory write port, then releases the pipeline and turns the memory port over to it. Sits between `Pipeline`, `Memory` and the board `uart_rx` pin, so a new program loads without rebuilding the memory initialisation file.

## Interface
- `CLK_DIV`, 1250: clock cycles per UART bit (12 MHz / 9600 baud); must be ≥ 4.
- `ADDR_W`, 11: memory word-address width; capacity 2^ADDR_W words.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high; single clock domain `clk`.
- `uart_rx` in 1: asynchronous serial input, idle high.
- `cpu_rstn` out 1: active-low reset to `Pipeline`.
- `cpu_wren` in 1: pipeline memory write enable.
- `cpu_wmask` in 4: pipeline byte mask.
- `cpu_wdata` in 32: pipeline write data.
- `cpu_addr` in ADDR_W: pipeline word address.
- `mem_wren` out 1: to `Memory`.
- `mem_wmask` out 4: to `Memory`.
- `mem_wdata` out 32: to `Memory`.
- `mem_addr` out ADDR_W: to `Memory`.
- `busy` out 1: high while not in RUN.
- `error` out 1: sticky, high in ERR.

## Operation
- Image format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian. Word k goes to word address k.
- UART receiver:
  - 2-flop synchroniser on `uart_rx`; a falling edge starts a byte.
  - Wait CLK_DIV/2 cycles, then re-check the line. If high, it was a glitch: return to idle, no byte.
  - Sample 8 data bits LSB first, CLK_DIV apart, then the stop bit.
  - At the stop sample, pulse `byte_valid` for 1 cycle with the data; if the stop bit is 0, pulse `frame_err` instead.
- Loader FSM:
  - LEN: shift in 4 bytes into `len` (32 bits).
    - On the 4th byte: if `len` = 0, go to RUN.
    - If `len` > 2^ADDR_W, go to ERR.
    - Otherwise go to DATA; word counter `wcnt` = 0.
  - DATA: assemble 4 bytes. On the 4th byte, issue one write (address `wcnt`, mask 4'hF) and increment `wcnt`. When `wcnt` reaches `len`, go to RUN.
  - RUN: terminal until `rst`. `uart_rx` is ignored. `mem_*` = `cpu_*` combinationally. `cpu_rstn` = 1.
  - ERR: entered on `frame_err` in LEN or DATA. `error` = 1, `cpu_rstn` = 0, no writes. Terminal until `rst`.
- Outside RUN, `mem_*` come from loader registers. `cpu_*` inputs are ignored.
- Width rules: `len` is compared as 32-bit unsigned. `wcnt` is ADDR_W+1 bits, so N = 2^ADDR_W is legal.

## Timing
- Reset values:
  - State LEN, byte count 0, `wcnt` 0.
  - `cpu_rstn` 0, `busy` 1, `error` 0.
  - `mem_wren` 0, `mem_wmask` 0, `mem_wdata` 0, `mem_addr` 0.
  - Receiver idle.
- Reset mid-load (`rst` in any state) discards partial bytes and words and restarts at LEN.
- A byte completes 9.5·CLK_DIV (±1) cycles after the start edge.
- A load write is registered: `mem_wren` is high exactly 1 cycle, the cycle after the 4th byte's `byte_valid`.
- RUN is entered in the same edge as the last write. `cpu_rstn` rises 1 cycle after the last `mem_wren` pulse.
  - For N = 0, `cpu_rstn` rises 1 cycle after the 4th length byte.
- Bytes are ≥ 10·CLK_DIV cycles apart, so a write never coincides with another `byte_valid`.
- `frame_err` takes precedence: a frame error on a byte that would complete a word produces no write.

## Structure
- Package `boot_pkg`:
  - FSM state enum (LEN, DATA, RUN, ERR).
  - Constant `DEFAULT_CLK_DIV` = 12_000_000/9600.
  - Constant `IMG_BYTES_PER_WORD` = 4.
- Sub-module `uart_rx_byte`: synchroniser, bit timer, shift register, `byte_valid`/`frame_err` outputs; parameter CLK_DIV.
- Top holds the FSM, byte assembly, write registers and the RUN pass-through mux.

## Test plan
- CLK_DIV=8, ADDR_W=11 throughout.
- Send 02 00 00 00 44 33 22 11 EF BE AD DE → writes [0]=0x11223344 then [1]=0xDEADBEEF, mask F, each a 1-cycle `mem_wren`; `cpu_rstn` 1 one cycle after the 2nd write; `busy` 0.
- Send 00 00 00 00 → no `mem_wren`; `cpu_rstn` 1 one cycle after the 4th byte.
- Length 01 08 00 00 (0x801) → `error`=1, `cpu_rstn` stays 0. Length 00 08 00 00 (0x800) is accepted.
- Stop bit forced 0 on the 3rd data byte → `error`=1, no write; pulse `rst` → `error` 0, state LEN, a fresh image loads correctly.
- `uart_rx` low for 2 cycles then high → no `byte_valid`; `busy` 1, byte count unchanged.
- In RUN: `cpu_wren`=1, `cpu_addr`=5, `cpu_wdata`=0xA5, `cpu_wmask`=1 → identical `mem_*` in the same cycle. Assert `rst` mid-DATA after 2 of 4 bytes → restart; a full image then loads from address 0.
